rx_controller: RTL
==================

RX_CONTROLLER -- requirements
Module: rx_controller

Interface
REQ-001 The block SHALL have one parameter, DEPTH, default 4: the number of byte entries in the receive FIFO (power of two, 2..16).
REQ-002 clk  input  1  peripheral clock; the block SHALL use this one clock only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 bit_ready  input  1  one-cycle pulse from the bit detector: rx_bit holds a valid data bit.
REQ-005 rx_bit  input  1  sampled data bit; valid only in a cycle where bit_ready=1.
REQ-006 active_rx  input  1  high while the bit detector is in its data or stop-bit phase.
REQ-007 done  input  1  one-cycle pulse at the end of the stop bit.
REQ-008 framing_err  input  1  qualifies done: stop bit was sampled low.
REQ-009 data_out  output  8  head byte of the FIFO.
REQ-010 data_out_valid  output  1  FIFO is non-empty.
REQ-011 data_out_ready  input  1  host accepts the head byte.
REQ-012 rx_busy  output  1  high when the FSM is not in IDLE.
REQ-013 fifo_count  output  $clog2(DEPTH)+1  number of occupied FIFO entries.
REQ-014 overrun_err  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-015 frame_err  output  1  sticky flag: a frame was discarded (bad stop bit or short frame).
REQ-016 err_clear  input  1  one-cycle pulse that clears both sticky flags.

Function
REQ-017 The FSM SHALL have three states: IDLE, ASSEMBLE and WAIT_STOP.
REQ-018 Transition IDLE->ASSEMBLE: on active_rx=1; at the same time clear the bit counter (3-bit) and the shift register (8-bit).
REQ-019 In ASSEMBLE, on each bit_ready: shift right with rx_bit entering bit 7, then increment the bit counter; bits are received LSB-first.
REQ-020 Transition ASSEMBLE->WAIT_STOP: on the bit_ready that carries the 8th bit (bit counter wraps 7->0); the shift register then holds the full byte.
REQ-021 Transition WAIT_STOP->IDLE: on done=1.
  - framing_err=0: push the byte into the FIFO in that same cycle.
  - framing_err=1: discard the byte and set frame_err.
REQ-022 Short frame: done=1 while in ASSEMBLE SHALL discard the partial byte, set frame_err and return to IDLE.
REQ-023 Abort: active_rx=0 while in ASSEMBLE or WAIT_STOP, with no done in that cycle, SHALL discard the frame silently and return to IDLE.
REQ-024 bit_ready pulses outside ASSEMBLE SHALL be ignored.
REQ-025 FIFO:
  - registered storage; data_out is driven combinationally from the entry at the read pointer.
  - read and write pointers wrap modulo DEPTH.
REQ-026 Pop happens when data_out_valid && data_out_ready; data_out_valid=(fifo_count!=0).
  - data_out and data_out_valid SHALL hold stable until popped.
REQ-027 Push when the FIFO is full with no pop in the same cycle: drop the byte, set overrun_err, leave FIFO contents and fifo_count unchanged.
REQ-028 Push and pop in the same cycle: both succeed and fifo_count is unchanged; this includes the full case (pop frees the slot first).
REQ-029 Empty: pop is impossible because valid=0; data_out is don't-care when valid=0.
REQ-030 Latency: a byte pushed in cycle N SHALL appear with data_out_valid=1 in cycle N+1 when the FIFO was empty.
REQ-031 Sticky flags: err_clear clears overrun_err and frame_err; a new error in the same cycle as err_clear wins (the flag stays set).

Reset
REQ-032 While rst=1 the block SHALL:
  - enter IDLE;
  - clear pointers, fifo_count, bit counter and shift register;
  - drive data_out_valid=0, rx_busy=0, overrun_err=0, frame_err=0 and data_out=8'h00.
  FIFO storage need not be cleared.
REQ-033 rst asserted mid-frame or with the FIFO non-empty SHALL discard all bytes, in-flight and stored; after rst deasserts, the next activity SHALL be the start of a new frame.

Verification
REQ-034 Nominal byte: frame with bits 1,0,1,0,0,1,0,1, then done with framing_err=0 -> data_out=8'hA5 and data_out_valid=1 one cycle after done; fifo_count=1.
REQ-035 Overrun (DEPTH=4): 5 good frames 8'h01..8'h05 with data_out_ready=0 -> fifo_count=4, overrun_err=1; the pops then return 01,02,03,04 and 05 is lost.
REQ-036 Framing error: frame 8'h3C with done and framing_err=1 -> no push, fifo_count=0, frame_err=1; err_clear then -> frame_err=0.
REQ-037 Short frame and abort:
  - done after 5 bits -> frame_err=1, FSM back in IDLE, no push.
  - active_rx drops after 3 bits -> no flag set, no push.
REQ-038 Simultaneous push/pop at full: FIFO full, a push arrives while data_out_ready=1 -> fifo_count stays 4, overrun_err=0, and the new byte is the last one popped.
REQ-039 Reset mid-frame: rst asserted after 4 bits with 2 bytes stored -> data_out_valid=0 and fifo_count=0; a following frame 8'h5A is received correctly.

Source files
------------

// File: rtl/rx_controller.sv
// Receive controller: assembles LSB-first serial bits into bytes and queues them
// in a small FIFO, with sticky overrun and framing error flags.
module rx_controller #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_ready,
  input  logic                     rx_bit,
  input  logic                     active_rx,
  input  logic                     done,
  input  logic                     framing_err,
  output logic [7:0]               data_out,
  output logic                     data_out_valid,
  input  logic                     data_out_ready,
  output logic                     rx_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overrun_err,
  output logic                     frame_err,
  input  logic                     err_clear
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StAssemble = 2'd1;
  localparam logic [1:0] StWaitStop = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;

  logic push_req;
  logic set_frame_err;
  logic pop;
  logic full;
  logic push_ok;

  // Frame assembly FSM
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    push_req      = 1'b0;
    set_frame_err = 1'b0;
    case (state_q)
      StIdle: begin
        if (active_rx) begin
          state_d   = StAssemble;
          bit_cnt_d = 3'd0;
          shift_d   = 8'h00;
        end
      end
      StAssemble: begin
        if (done) begin
          set_frame_err = 1'b1;
          state_d       = StIdle;
        end else if (!active_rx) begin
          state_d = StIdle;
        end else if (bit_ready) begin
          shift_d   = {rx_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StWaitStop;
          end
        end
      end
      StWaitStop: begin
        if (done) begin
          push_req      = !framing_err;
          set_frame_err = framing_err;
          state_d       = StIdle;
        end else if (!active_rx) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO; a pop in the same cycle frees the slot for a push at full
  always_comb begin
    pop      = data_out_valid && data_out_ready;
    full     = (count_q == FullCount);
    push_ok  = push_req && (!full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // A new error in the same cycle as err_clear keeps the flag set
  always_comb begin
    overrun_d   = err_clear ? 1'b0 : overrun_q;
    frame_err_d = err_clear ? 1'b0 : frame_err_q;
    if (push_req && full && !pop) begin
      overrun_d = 1'b1;
    end
    if (set_frame_err) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    data_out_valid = (count_q != '0);
    data_out       = data_out_valid ? mem_q[rd_ptr_q] : 8'h00;
    rx_busy        = (state_q != StIdle);
    fifo_count     = count_q;
    overrun_err    = overrun_q;
    frame_err      = frame_err_q;
  end

endmodule
